// File: rtl/result_uart_tx.sv
// result_uart_tx
//   Transmits one fixed-length classifier result packet over an 8N1 UART
//   line for every rising edge of the engine's done level.
//
//   Packet (bytes in order, each START / 8 data LSB-first / STOP):
//     B0 = 8'hA5
//     B1 = {6'b0, K_mode, predicted_class}
//     B2 = latency[15:8]
//     B3 = latency[7:0]
//     B4 = B0^B1^B2^B3         (only when CHECKSUM_EN is defined)
//
//   Configuration macro: CHECKSUM_EN  (undefined -> 4-byte packet, no checksum)
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency
//   BAUD         line rate; CLKS_PER_BIT = CLK_FREQ_HZ / BAUD, must be >= 4
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-low reset
//   done             classification done level; rising edge triggers a packet
//   predicted_class  class bit, sampled at trigger
//   K_mode           K selection bit, sampled at trigger
//   latency[15:0]    classification latency, sampled at trigger
//   tx               UART line, idle high, registered
//   busy             high while a packet is in flight
//   sent             one-cycle pulse when the final stop bit completes
//   overrun          sticky; a trigger arrived while busy (cleared by reset only)

module result_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic        predicted_class,
  input  logic        K_mode,
  input  logic [15:0] latency,
  output logic        tx,
  output logic        busy,
  output logic        sent,
  output logic        overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
`ifdef CHECKSUM_EN
  localparam logic [2:0]  LAST_BYTE    = 3'd4;
`else
  localparam logic [2:0]  LAST_BYTE    = 3'd3;
`endif

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("result_uart_tx: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [2:0]          byte_q, byte_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                sent_q, sent_d;
  logic                ovr_q, ovr_d;
  logic                done_q;
  logic [1:0]          kp_q, kp_d;
  logic [15:0]         lat_q, lat_d;

  logic                trig;
  logic                bit_end;
  logic                start_pkt;
  logic [2:0]          bit_nx;
  logic [7:0]          cur_byte;

  assign trig    = done & ~done_q;
  assign bit_end = (baud_q == BAUD_LAST);
  assign bit_nx  = bit_q + 3'd1;

`ifdef CHECKSUM_EN
  logic [7:0] csum;
  assign csum = SYNC_BYTE ^ {6'b0, kp_q} ^ lat_q[15:8] ^ lat_q[7:0];
`endif

  // Byte currently being serialised, built from the frozen snapshot.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = {6'b0, kp_q};
      3'd2:    cur_byte = lat_q[15:8];
      3'd3:    cur_byte = lat_q[7:0];
`ifdef CHECKSUM_EN
      3'd4:    cur_byte = csum;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    sent_d    = 1'b0;
    ovr_d     = ovr_q;
    kp_d      = kp_q;
    lat_d     = lat_q;
    start_pkt = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trig) start_pkt = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = cur_byte[bit_nx];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_q == LAST_BYTE) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            sent_d  = 1'b1;
            // A trigger landing on the final stop edge chains straight into
            // the next packet; busy never drops.
            if (trig) start_pkt = 1'b1;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (trig && !start_pkt) ovr_d = 1'b1;

    if (start_pkt) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = 3'd0;
      byte_d  = 3'd0;
      tx_d    = 1'b0;
      kp_d    = {K_mode, predicted_class};
      lat_d   = latency;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b1;   // a done already high out of reset is not an edge
      kp_q    <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
      ovr_q   <= ovr_d;
      done_q  <= done;
      kp_q    <= kp_d;
      lat_q   <= lat_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign sent    = sent_q;
  assign overrun = ovr_q;

endmodule
